// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch-predictor update stage.
//   - 2-bit saturating counter encodings
//   - predictor table entry layout (18 bits)
//   - sat_next(): next counter state for a resolved direction
// ---------------------------------------------------------------------------
package bp_pkg;

    // Counter encodings: strongly/weakly not-taken, weakly/strongly taken
    localparam logic [1:0] ST_SNT   = 2'b00;
    localparam logic [1:0] ST_WNT   = 2'b01;
    localparam logic [1:0] ST_WT    = 2'b10;
    localparam logic [1:0] ST_ST    = 2'b11;
    localparam logic [1:0] ST_ALLOC = ST_WT;

    // Table entry layout
    localparam int ENT_W      = 18;
    localparam int ENT_V      = 17;
    localparam int ENT_ST_HI  = 16;
    localparam int ENT_ST_LO  = 15;
    localparam int ENT_TAG_HI = 14;
    localparam int ENT_TAG_LO = 13;
    localparam int ENT_TGT_HI = 12;
    localparam int ENT_TGT_LO = 0;

    // Next counter state after one resolved outcome, saturating at both ends
    function automatic logic [1:0] sat_next(input logic [1:0] state, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (state == ST_ST) ? ST_ST : state + 2'b01;
        end else begin
            res = (state == ST_SNT) ? ST_SNT : state - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// ---------------------------------------------------------------------------
// bp_upd_fifo
// Two-push / one-pop FIFO holding pending predictor-table updates.
//   CLK    : clock, all state on posedge
//   RST_X  : asynchronous active-low reset (empties the queue)
//   push1/data1, push2/data2 : up to two pushes per cycle, slot 1 first.
//                              A lone push2 lands in the first free slot.
//   pop    : remove the head entry (ignored when empty)
//   count  : number of valid entries
//   head   : registered head entry, valid whenever count != 0
// The caller must never push more entries than DEPTH - count + pop.
// ---------------------------------------------------------------------------
module bp_upd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 29
) (
    input  logic                       CLK,
    input  logic                       RST_X,
    input  logic                       push1,
    input  logic [DATA_W-1:0]          data1,
    input  logic                       push2,
    input  logic [DATA_W-1:0]          data2,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DATA_W-1:0]          head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next, wr_ptr_p1;
    logic [CNT_W-1:0]  count_reg, count_next, remaining;
    logic [DATA_W-1:0] head_reg, head_next;
    logic [DATA_W-1:0] first_data;
    logic [1:0]        n_push;
    logic              pop_eff;

    always_comb begin
        pop_eff     = pop && (count_reg != '0);
        n_push      = {1'b0, push1} + {1'b0, push2};
        first_data  = push1 ? data1 : data2;
        wr_ptr_p1   = wr_ptr_reg + PTR_W'(1);
        // Power-of-two depth: pointers wrap by natural overflow
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop_eff);
        wr_ptr_next = wr_ptr_reg + PTR_W'(n_push);
        remaining   = count_reg - CNT_W'(pop_eff);
        count_next  = remaining + CNT_W'(n_push);
        // Head is looked up one edge early so it is registered. If nothing
        // old survives this edge, the new head is the first entry pushed now
        // (that also gives the one-edge latency from input to w_*).
        head_next   = head_reg;
        if (remaining != '0) begin
            head_next = mem[rd_ptr_next];
        end else if (n_push != 2'd0) begin
            head_next = first_data;
        end
    end

    // Storage carries no reset so it maps onto plain RAM/LUTRAM
    always_ff @(posedge CLK) begin
        if (push1 && push2) begin
            mem[wr_ptr_reg] <= data1;
            mem[wr_ptr_p1]  <= data2;
        end else if (push1 || push2) begin
            mem[wr_ptr_reg] <= first_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    assign count = count_reg;
    assign head  = head_reg;

endmodule

// File: rtl/bp_update.sv
// ---------------------------------------------------------------------------
// bp_update
// Branch-predictor update stage between dual-issue Execute and the
// predictor table. Computes the next 2-bit counter state for up to two
// resolved control transfers per cycle, queues the resulting table entries
// and drains them one per cycle into the table's single write port.
//   CLK, RST_X          : clock / asynchronous active-low reset
//   e_valid1/2          : slot holds a resolved branch/jump this cycle
//   e_pc1/2             : word PC (index = pc[10:0], tag = pc[12:11])
//   e_taken1/2          : resolved direction
//   e_target1/2         : resolved target
//   e_state1/2          : counter state read at fetch
//   e_tagok1/2          : entry valid and tag matched at fetch
//   w_addr/w_data/wen   : table write port (head of queue)
//   drop_cnt            : saturating count of updates lost to a full queue
// ---------------------------------------------------------------------------
module bp_update
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 13,
    parameter int IDX_W = 11,
    parameter int TAG_W = 2,
    parameter int CNT_W = 8
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic              e_valid1,
    input  logic [PC_W-1:0]   e_pc1,
    input  logic              e_taken1,
    input  logic [PC_W-1:0]   e_target1,
    input  logic [1:0]        e_state1,
    input  logic              e_tagok1,
    input  logic              e_valid2,
    input  logic [PC_W-1:0]   e_pc2,
    input  logic              e_taken2,
    input  logic [PC_W-1:0]   e_target2,
    input  logic [1:0]        e_state2,
    input  logic              e_tagok2,
    output logic [IDX_W-1:0]  w_addr,
    output logic [ENT_W-1:0]  w_data,
    output logic              wen,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int FIFO_W = IDX_W + ENT_W;
    localparam int FCNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W  = CNT_W + 1;

    // Slot-indexed views of the two issue slots
    logic [1:0]      valid_s, taken_s, tagok_s;
    logic [PC_W-1:0] pc_s  [2];
    logic [PC_W-1:0] tgt_s [2];
    logic [1:0]      state_s [2];
    logic [1:0]      base_raw [2];
    logic [1:0]      upd_raw;
    logic [1:0]      nst_s [2];
    logic [FIFO_W-1:0] ent_s [2];

    assign valid_s    = {e_valid2, e_valid1};
    assign taken_s    = {e_taken2, e_taken1};
    assign tagok_s    = {e_tagok2, e_tagok1};
    assign pc_s[0]    = e_pc1;
    assign pc_s[1]    = e_pc2;
    assign tgt_s[0]   = e_target1;
    assign tgt_s[1]   = e_target2;
    assign state_s[0] = e_state1;
    assign state_s[1] = e_state2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            // A miss starts from weakly-not-taken, so a taken miss lands on
            // ST_ALLOC through the normal increment.
            assign base_raw[gi] = tagok_s[gi] ? state_s[gi] : ST_WNT;
            // A not-taken miss has nothing worth allocating
            assign upd_raw[gi]  = valid_s[gi] && (tagok_s[gi] || taken_s[gi]);
            assign ent_s[gi]    = {pc_s[gi][IDX_W-1:0], 1'b1, nst_s[gi],
                                   pc_s[gi][IDX_W+TAG_W-1:IDX_W], tgt_s[gi]};
        end
    endgenerate

    logic              same_idx, merge;
    logic [1:0]        base2;
    logic              want1, want2;
    logic              push1, push2;
    logic [1:0]        n_drop;
    logic [FCNT_W-1:0] fifo_count, free_slots;
    logic [FIFO_W-1:0] fifo_head;
    logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;
    logic [SUM_W-1:0]  drop_sum;

    always_comb begin
        same_idx = e_valid1 && e_valid2 &&
                   (e_pc1[IDX_W-1:0] == e_pc2[IDX_W-1:0]);
        // Slot 2 is younger: it trains on top of slot 1's result and the
        // combined outcome is written once. Once slot 1 has created or
        // refreshed the entry, slot 2 always has something to update.
        merge    = same_idx && upd_raw[0];
        nst_s[0] = sat_next(base_raw[0], e_taken1);
        base2    = merge ? nst_s[0] : base_raw[1];
        nst_s[1] = sat_next(base2, e_taken2);
        want1    = upd_raw[0] && !merge;
        want2    = upd_raw[1] || merge;

        // A pop on this edge frees one slot for the incoming pushes
        free_slots = FCNT_W'(DEPTH) - fifo_count + FCNT_W'(wen);

        // Slot 2 is sacrificed first when space runs short
        push1  = 1'b0;
        push2  = 1'b0;
        n_drop = 2'd0;
        if (want1 && want2) begin
            if (free_slots >= FCNT_W'(2)) begin
                push1 = 1'b1;
                push2 = 1'b1;
            end else if (free_slots >= FCNT_W'(1)) begin
                push1  = 1'b1;
                n_drop = 2'd1;
            end else begin
                n_drop = 2'd2;
            end
        end else if (want1) begin
            if (free_slots != '0) push1  = 1'b1;
            else                  n_drop = 2'd1;
        end else if (want2) begin
            if (free_slots != '0) push2  = 1'b1;
            else                  n_drop = 2'd1;
        end

        drop_sum      = {1'b0, drop_cnt_reg} + SUM_W'(n_drop);
        drop_cnt_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    bp_upd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (FIFO_W)
    ) u_fifo (
        .CLK    (CLK),
        .RST_X  (RST_X),
        .push1  (push1),
        .data1  (ent_s[0]),
        .push2  (push2),
        .data2  (ent_s[1]),
        .pop    (wen),
        .count  (fifo_count),
        .head   (fifo_head)
    );

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            drop_cnt_reg <= '0;
        end else begin
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // The table consumes the head on the edge after it appears
    assign wen      = (fifo_count != '0);
    assign w_addr   = fifo_head[FIFO_W-1:ENT_W];
    assign w_data   = fifo_head[ENT_W-1:0];
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_bp_update.sv
// ---------------------------------------------------------------------------
// tb_bp_update
// Self-checking bench for bp_update: directed scenarios followed by random
// dual-slot traffic, checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_bp_update;
    localparam int DEPTH = 4;
    localparam int PC_W  = 13;
    localparam int IDX_W = 11;
    localparam int CNT_W = 8;

    logic              CLK = 1'b0;
    logic              RST_X = 1'b0;
    logic              e_valid1, e_valid2;
    logic [PC_W-1:0]   e_pc1, e_pc2;
    logic              e_taken1, e_taken2;
    logic [PC_W-1:0]   e_target1, e_target2;
    logic [1:0]        e_state1, e_state2;
    logic              e_tagok1, e_tagok2;
    logic [IDX_W-1:0]  w_addr;
    logic [17:0]       w_data;
    logic              wen;
    logic [CNT_W-1:0]  drop_cnt;

    bp_update #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(2), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_X(RST_X),
        .e_valid1(e_valid1), .e_pc1(e_pc1), .e_taken1(e_taken1),
        .e_target1(e_target1), .e_state1(e_state1), .e_tagok1(e_tagok1),
        .e_valid2(e_valid2), .e_pc2(e_pc2), .e_taken2(e_taken2),
        .e_target2(e_target2), .e_state2(e_state2), .e_tagok2(e_tagok2),
        .w_addr(w_addr), .w_data(w_data), .wen(wen), .drop_cnt(drop_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int addr;
        int data;
    } upd_t;

    upd_t q[$];
    int   m_drops = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic upd_t mk(input int pc, input int st, input int tgt);
        upd_t u;
        u.addr = pc % 2048;
        u.data = (1 << 17) + (st << 15) + (((pc >> 11) % 4) << 13) + (tgt % 8192);
        return u;
    endfunction

    function automatic int train(input int base, input bit taken);
        if (taken) return (base == 3) ? 3 : base + 1;
        return (base == 0) ? 0 : base - 1;
    endfunction

    task automatic set_slot(input int s, input bit v, input int pc, input bit tk,
                            input int tgt, input int st, input bit ok);
        if (s == 1) begin
            e_valid1 = v; e_pc1 = pc[12:0]; e_taken1 = tk;
            e_target1 = tgt[12:0]; e_state1 = st[1:0]; e_tagok1 = ok;
        end else begin
            e_valid2 = v; e_pc2 = pc[12:0]; e_taken2 = tk;
            e_target2 = tgt[12:0]; e_state2 = st[1:0]; e_tagok2 = ok;
        end
    endtask

    task automatic idle();
        set_slot(1, 0, 0, 0, 0, 0, 0);
        set_slot(2, 0, 0, 0, 0, 0, 0);
    endtask

    // Apply the update rules to the current inputs and advance the queue
    // model by one clock edge.
    task automatic model_edge();
        int   base1, n1, base2, n2, free_n;
        bit   u1, u2, same;
        upd_t w[$];
        upd_t tmp;
        base1 = e_tagok1 ? int'(e_state1) : 1;
        n1    = train(base1, e_taken1);
        u1    = e_valid1 && (e_tagok1 || e_taken1);
        same  = e_valid1 && e_valid2 && ((int'(e_pc1) % 2048) == (int'(e_pc2) % 2048));
        if (same && u1) begin
            base2 = n1;
            u2    = 1'b1;
            u1    = 1'b0;
        end else begin
            base2 = e_tagok2 ? int'(e_state2) : 1;
            u2    = e_valid2 && (e_tagok2 || e_taken2);
        end
        n2 = train(base2, e_taken2);
        if (u1) w.push_back(mk(int'(e_pc1), n1, int'(e_target1)));
        if (u2) w.push_back(mk(int'(e_pc2), n2, int'(e_target2)));
        free_n = DEPTH - q.size();
        if (q.size() != 0) begin
            tmp = q.pop_front();
            free_n++;
        end
        foreach (w[i]) begin
            if (free_n > 0) begin
                q.push_back(w[i]);
                free_n--;
            end else begin
                m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
            end
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge CLK);
        #1;
        cyc++;
        check({tag, "_wen"}, 32'(wen), 32'(q.size() != 0));
        check({tag, "_drop"}, 32'(drop_cnt), 32'(m_drops));
        if (q.size() != 0) begin
            check({tag, "_addr"}, 32'(w_addr), 32'(q[0].addr));
            check({tag, "_data"}, 32'(w_data), 32'(q[0].data));
        end
        $display("[TB] cyc %0d %s wen=%0b addr=%03h data=%05h drops=%0d",
                 cyc, tag, wen, w_addr, w_data, drop_cnt);
    endtask

    initial begin
        int pc1, pc2;
        idle();

        // 1: held in reset, then idle
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check("t1_rst_wen", 32'(wen), 32'd0);
            check("t1_rst_drop", 32'(drop_cnt), 32'd0);
        end
        RST_X = 1'b1;
        for (int i = 0; i < 3; i++) step("t1_idle");

        // 2: single taken hit
        set_slot(1, 1, 'h1A05, 1, 'h0123, 1, 1);
        step("t2");
        check("t2_wen", 32'(wen), 32'd1);
        check("t2_addr", 32'(w_addr), 32'h205);
        check("t2_data", 32'(w_data), 32'h36123);
        idle();
        step("t2_after");
        check("t2_after_wen", 32'(wen), 32'd0);

        // 3: miss, not taken -> nothing
        set_slot(1, 1, 'h0333, 0, 'h0044, 2, 0);
        step("t3");
        check("t3_wen", 32'(wen), 32'd0);
        check("t3_drop", 32'(drop_cnt), 32'd0);

        // 4: allocate, saturate high, saturate low
        set_slot(1, 1, 'h0444, 1, 'h0055, 0, 0);
        step("t4_alloc");
        check("t4_alloc_st", 32'(w_data[16:15]), 32'd2);
        set_slot(1, 1, 'h0445, 1, 'h0066, 3, 1);
        step("t4_sat_hi");
        check("t4_sat_hi_st", 32'(w_data[16:15]), 32'd3);
        set_slot(1, 1, 'h0446, 0, 'h0077, 0, 1);
        step("t4_sat_lo");
        check("t4_sat_lo_st", 32'(w_data[16:15]), 32'd0);
        idle();
        step("t4_drain");

        // 5: same-index pair merges into one write
        set_slot(1, 1, 'h0010, 1, 'h0100, 1, 1);
        set_slot(2, 1, 'h0810, 1, 'h0200, 1, 1);
        step("t5");
        check("t5_st", 32'(w_data[16:15]), 32'd3);
        check("t5_addr", 32'(w_addr), 32'h010);
        idle();
        step("t5_after");
        check("t5_single", 32'(wen), 32'd0);

        // 6: dual taken every cycle overfills the queue
        for (int k = 0; k < 6; k++) begin
            set_slot(1, 1, 'h100 + 2 * k, 1, 'h10 + k, 1, 1);
            set_slot(2, 1, 'h101 + 2 * k, 1, 'h20 + k, 2, 1);
            step("t6");
        end
        check("t6_drops", 32'(drop_cnt), 32'd3);
        idle();
        #2;
        RST_X = 1'b0;
        #1;
        check("t6_rst_wen", 32'(wen), 32'd0);
        check("t6_rst_drop", 32'(drop_cnt), 32'd0);
        q.delete();
        m_drops = 0;
        @(posedge CLK);
        #1;
        check("t6_rst_hold", 32'(wen), 32'd0);
        RST_X = 1'b1;
        step("t6_post");

        // Random dual-slot traffic
        for (int i = 0; i < 400; i++) begin
            pc1 = $urandom_range(0, 8191);
            pc2 = $urandom_range(0, 8191);
            if ($urandom_range(0, 3) == 0) pc2 = ($urandom_range(0, 3) << 11) + (pc1 % 2048);
            set_slot(1, $urandom_range(0, 9) < 7, pc1, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 8191), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
            set_slot(2, $urandom_range(0, 9) < 7, pc2, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 8191), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
            step("rnd");
        end

        // Sustained overload drives the drop counter into saturation
        for (int i = 0; i < 300; i++) begin
            set_slot(1, 1, $urandom_range(0, 8191), 1, $urandom_range(0, 8191), $urandom_range(0, 3), 1);
            set_slot(2, 1, $urandom_range(0, 8191), 1, $urandom_range(0, 8191), $urandom_range(0, 3), 0);
            step("sat");
        end
        check("sat_drop", 32'(drop_cnt), 32'd255);
        idle();
        for (int i = 0; i < 6; i++) step("final_drain");
        check("final_empty", 32'(wen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
